vga_scan_timing: RTL and testbench

// - Generates 640x480@60Hz raster timing from the 100 MHz board clock.
// - Issues pixel coordinates to the upstream tile/sprite renderer.
// - Takes back its 12-bit pixel colour after a fixed read latency.
// - Drives hs/vs/r/g/b to the VGA connector with sync and blanking aligned to the returned colour.
// - Sits directly downstream of the renderer that consumes vga x/y and returns vga data.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_scan_timing.sv | 109 ++++++++++
 tb/tb_vga_scan_timing.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and colour type for the 640x480@60Hz VGA scan path.
package vga_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int RD_LAT   = 1;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages; every stage resets to RST_VAL.
module vga_delay_line #(
    parameter int             DEPTH   = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster timing: pixel-tick divider, h/v counters, renderer requests and
// sync/blank alignment to the renderer's returned colour.
module vga_scan_timing
    import vga_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP,
    parameter int LAT      = RD_LAT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_req,
    output logic        pix_tick,
    output logic        frame_start,
    input  logic [11:0] pix_data,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int HT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
    localparam int VT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACT);
    localparam logic [9:0] V_VIS  = 10'(V_ACT);
    localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_ACT + H_FRONT + H_SYNC_W - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_ACT + V_FRONT + V_SYNC_W - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_raw;
    logic          vs_raw;
    logic [2:0]    pipe_q;
    rgb12_t        rgb_q;

    assign pix_tick = (div_cnt == DIV_LAST);
    assign h_wrap   = (h_cnt == H_LAST);
    assign v_wrap   = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_tick ? '0 : DW'(div_cnt + 1'b1);
            if (pix_tick) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
                if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end
        end
    end

    assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);
    assign pix_req     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign pix_x       = pix_req ? h_cnt : '0;
    assign pix_y       = pix_req ? v_cnt[8:0] : '0;
    assign hs_raw      = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    assign vs_raw      = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));

    // Syncs reset high (inactive) and req low so nothing is shown before real data returns.
    vga_delay_line #(
        .DEPTH   (LAT),
        .W       (3),
        .RST_VAL (3'b011)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .en  (pix_tick),
        .d   ({pix_req, hs_raw, vs_raw}),
        .q   (pipe_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs    <= 1'b1;
            vs    <= 1'b1;
            rgb_q <= '0;
        end else if (pix_tick) begin
            hs    <= pipe_q[1];
            vs    <= pipe_q[0];
            rgb_q <= pipe_q[2] ? rgb12_t'(pix_data) : '0;
        end
    end

    assign r = rgb_q.r;
    assign g = rgb_q.g;
    assign b = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: full-width lines, shortened frame (8 lines) to keep the run short.
module tb_vga_scan_timing;

    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = 800;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_req;
    logic        pix_tick;
    logic        frame_start;
    logic [11:0] pix_data;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    int checks = 0;
    int errors = 0;

    int c = 0;
    int mode = 0;
    logic [11:0] d_km1 = '0;
    logic [11:0] d_km2 = '0;
    bit chk_en = 0;

    bit prev_hs = 1, prev_vs = 1;
    bit have_hfall = 0, first_hfall_seen = 0, have_vfall = 0, have_fs = 0;
    int hfall_c, vfall_c, fs_c;

    vga_scan_timing #(
        .V_ACT    (VA),
        .V_FRONT  (VF),
        .V_SYNC_W (VS),
        .V_BACK   (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .pix_data    (pix_data),
        .hs          (hs),
        .vs          (vs),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (c=%0d)", name, act, exp, c);
        end
    endtask

    // Raster position of pixel tick number n counted from reset release.
    function automatic void pos(input int n, output int h, output int v);
        int p;
        p = n % FT;
        h = p % HT;
        v = p / HT;
    endfunction

    function automatic bit active(input int h, input int v);
        return (h < 640) && (v < VA);
    endfunction

    function automatic logic [11:0] gen(input int j);
        int h, v;
        logic [9:0] hh;
        logic [9:0] vv;
        pos(j, h, v);
        hh = 10'(h);
        vv = 10'(v);
        case (mode)
            0: gen = active(h, v) ? {hh[3:0], vv[3:0], 4'hA} : 12'($urandom_range(0, 4095));
            1: gen = 12'hFFF;
            default: gen = 12'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!rst) begin
                c++;
                if (c % 4 == 0) begin
                    d_km2    = d_km1;
                    d_km1    = gen(c / 4 - 1);
                    pix_data = d_km1;
                end
            end
        end
    endtask

    // Per-cycle comparison against the raster model.
    always @(negedge clk) begin
        int k, h, v, h2, v2;
        bit etick, ereq, efs, ehs, evs;
        int ergb;
        if (chk_en) begin
            k = c / 4;
            etick = (c % 4 == 3);
            pos(k, h, v);
            ereq = active(h, v);
            efs = etick && (k % FT == 0);
            ehs = 1; evs = 1; ergb = 0;
            if (k >= 2) begin
                pos(k - 2, h2, v2);
                ehs = !(h2 >= 656 && h2 <= 751);
                evs = !(v2 >= VA + VF && v2 <= VA + VF + VS - 1);
                ergb = active(h2, v2) ? int'(d_km2) : 0;
            end
            chk("pix_tick", int'(pix_tick), int'(etick));
            chk("frame_start", int'(frame_start), int'(efs));
            chk("pix_req", int'(pix_req), int'(ereq));
            chk("pix_x", int'(pix_x), ereq ? h : 0);
            chk("pix_y", int'(pix_y), ereq ? v : 0);
            chk("hs", int'(hs), int'(ehs));
            chk("vs", int'(vs), int'(evs));
            chk("rgb", int'({r, g, b}), ergb);

            if (prev_hs && !hs) begin
                if (!first_hfall_seen) begin
                    chk("hs_first_fall_clk", c, 2632);
                    first_hfall_seen = 1;
                end
                if (have_hfall) chk("hs_period_clks", c - hfall_c, 3200);
                hfall_c = c;
                have_hfall = 1;
            end
            if (!prev_hs && hs && have_hfall) chk("hs_low_clks", c - hfall_c, 384);
            if (prev_vs && !vs) begin
                vfall_c = c;
                have_vfall = 1;
            end
            if (!prev_vs && vs && have_vfall) chk("vs_low_clks", c - vfall_c, 6400);
            if (frame_start) begin
                if (have_fs) chk("frame_period_clks", c - fs_c, FT * 4);
                fs_c = c;
                have_fs = 1;
            end
            prev_hs = hs;
            prev_vs = vs;
        end
    end

    task automatic clear_trackers();
        prev_hs = 1; prev_vs = 1;
        have_hfall = 0; first_hfall_seen = 0; have_vfall = 0; have_fs = 0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        pix_data = 12'($urandom_range(0, 4095));
        chk_en = 1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame 1: coordinate pattern renderer.
        mode = 0;
        run(2);
        chk("lit_tick_c2", int'(pix_tick), 0);
        run(1);
        chk("lit_tick_c3", int'(pix_tick), 1);
        chk("lit_fs_c3", int'(frame_start), 1);
        chk("lit_hs_c3", int'(hs), 1);
        chk("lit_rgb_c3", int'({r, g, b}), 0);
        run(25);
        chk("lit_rgb_x5y0", int'({r, g, b}), 12'h50A);
        run(4 * 640 - 28 + 8);
        chk("lit_rgb_blank", int'({r, g, b}), 0);
        run(FT * 4 - 4 * 648 + 4);

        // Frame 2: constant white data, blanking must still be black.
        mode = 1;
        run(FT * 4);

        // Frame 3: random data, then async reset mid-line at h=300, row 2.
        mode = 2;
        guard = 0;
        while (!((c % 4 == 0) && ((c / 4) % FT == 2 * HT + 300)) && guard < FT * 4) begin
            run(1);
            guard++;
        end
        chk("reset_target_reached", int'(guard < FT * 4), 1);
        rst = 1'b1;
        c = 0;
        d_km1 = '0;
        d_km2 = '0;
        clear_trackers();
        #1;
        chk("async_rst_hs", int'(hs), 1);
        chk("async_rst_vs", int'(vs), 1);
        chk("async_rst_rgb", int'({r, g, b}), 0);
        chk("async_rst_tick", int'(pix_tick), 0);
        chk("async_rst_x", int'(pix_x), 0);
        run(3);
        rst = 1'b0;
        mode = 0;
        run(3);
        chk("lit_fs_after_rst", int'(frame_start), 1);
        run(4 * 800 + 400);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
